// File: rtl/fifo_axis_pkg.sv
// rtl/fifo_axis_pkg.sv - shared types and constants for the FIFO-to-AXIS packet source
//
// Purpose: FSM state encoding, skid depth, and the default-width beat record
// used by fifo_axis_source and axis_skid_buffer.
// Ports: none (package).

package fifo_axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SKID_DEPTH      = 2;
  localparam int BEAT_DATA_WIDTH = 32;

  // Beat record at the default data width. Parameterised instances build the
  // same layout locally with their own DATA_WIDTH.
  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0] data;
    logic                       last;
  } beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered buffer between FIFO pops and an AXIS master port
//
// Purpose: holds up to two popped words (with their last tag) so that the pop
// decision never depends on m_axis_tready. The head entry drives the stream
// outputs directly from flops.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   in_valid, in_data,       one beat written per cycle in_valid is high;
//   in_last                  caller only asserts in_valid while space is high
//   space                    occupancy below SKID_DEPTH (from registered occupancy)
//   m_axis_tvalid/tready/    AXI4-Stream master beat interface
//   tdata/tlast

module axis_skid_buffer
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  space,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } skid_beat_t;

  skid_beat_t head_q, head_d;
  skid_beat_t tail_q, tail_d;
  logic [1:0] occ_q, occ_d;

  skid_beat_t in_beat;
  logic       push;
  logic       pop;

  assign in_beat       = '{data: in_data, last: in_last};
  assign space         = (occ_q < 2'(SKID_DEPTH));
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tlast  = head_q.last;

  assign push = in_valid && space;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = in_beat;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        // Push with a concurrent accept replaces the head in place, keeping
        // occupancy at one and preserving order.
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d = in_beat;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_axis_source.sv
// rtl/fifo_axis_source.sv - FWFT FIFO reader that emits fixed-length AXI4-Stream packets
//
// Purpose: on start, pops cfg_len words from the FIFO read port and sends them
// as AXIS beats with TLAST on the final one; counts completed packets.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   if_empty_n, if_dout               FIFO head present / head word (FWFT)
//   if_read_ce, if_read               FIFO read enable (constant 1) / pop strobe
//   start, cfg_len                    begin a packet of cfg_len beats
//   busy, done, pkt_count             packet in progress / completion pulse / completed count
//   m_axis_tvalid/tready/tdata/tlast  AXI4-Stream master

module fifo_axis_source
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_empty_n,
  output logic                  if_read_ce,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  pkt_count,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] sent_q, sent_d;
  logic [LEN_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 done_q, done_d;

  logic skid_space;
  logic pop_last;
  logic accept;

  assign if_read_ce = 1'b1;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign pkt_count  = pkt_count_q;

  // Gating with reset_n keeps the FIFO untouched during the reset cycle, when
  // state_q may still read RUN.
  assign if_read  = reset_n && (state_q == RUN) && if_empty_n &&
                    (issued_q < len_q) && skid_space;
  assign pop_last = (issued_q == len_q - LEN_WIDTH'(1));
  assign accept   = m_axis_tvalid && m_axis_tready;

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (if_read),
    .in_data       (if_dout),
    .in_last       (pop_last),
    .space         (skid_space),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    pkt_count_d = pkt_count_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = cfg_len;
          issued_d = '0;
          sent_d   = '0;
          if (cfg_len == '0) begin
            done_d      = 1'b1;
            pkt_count_d = pkt_count_q + LEN_WIDTH'(1);
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        if (if_read) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (accept) begin
          sent_d = sent_q + LEN_WIDTH'(1);
          if (sent_q == len_q - LEN_WIDTH'(1)) begin
            done_d      = 1'b1;
            pkt_count_d = pkt_count_q + LEN_WIDTH'(1);
            state_d     = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      pkt_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      pkt_count_q <= pkt_count_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_source.sv
// tb/tb_fifo_axis_source.sv - scoreboard bench for fifo_axis_source
module tb_fifo_axis_source;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_empty_n = 1'b0;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout = '0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] pkt_count;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  always #5 clk = ~clk;

  fifo_axis_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_empty_n    (if_empty_n),
    .if_read_ce    (if_read_ce),
    .if_read       (if_read),
    .if_dout       (if_dout),
    .start         (start),
    .cfg_len       (cfg_len),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];
  time           acc_time[$];
  bit            tog_mode = 0;
  bit            zero_req = 0;
  int            pop_total = 0;
  int            acc_total = 0;
  int            done_cnt = 0;
  logic [LW-1:0] exp_pkt = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    if_empty_n = (fifo_q.size() != 0);
    if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock step: the FIFO model pops on the edge it saw if_read, then the
  // sink toggles tready when backpressure mode is on.
  task automatic tick();
    logic pop_now;
    @(posedge clk);
    pop_now = if_read && if_empty_n;
    #1;
    if (pop_now && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_total++;
    end
    refresh();
    #1;
    if (tog_mode) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic push_word(logic [DW-1:0] w, logic last);
    fifo_q.push_back(w);
    exp_q.push_back({w, last});
    refresh();
  endtask

  task automatic start_pkt(logic [LW-1:0] len, bit idle);
    start   = 1'b1;
    cfg_len = len;
    if (len == '0 && idle) zero_req = 1'b1;
    tick();
    start    = 1'b0;
    zero_req = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check(name, (n < 300), 1);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    exp_pkt = '0;
    tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_if_read", if_read, 0);
    pop_total = acc_total;
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: scoreboard pops, AXIS hold rule, done timing, skid occupancy.
  bit            done_due = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin : monitor
    logic [DW:0] e;
    if (!reset_n) begin
      done_due   = 0;
      prev_stall = 0;
    end else begin
      if (done || done_due) check("done_timing", done, done_due);
      if (done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid) check("pop_ahead", ((pop_total - acc_total) <= 2), 1);
      done_due = (m_axis_tvalid && m_axis_tready && m_axis_tlast) || zero_req;
      if (m_axis_tvalid && m_axis_tready) begin
        acc_total++;
        acc_time.push_back($time);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL beat_unexpected: got %0h expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e[DW:1]);
          check("beat_last", m_axis_tlast, e[0]);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int pops_before;

    // Reset state
    refresh();
    tick();
    tick();
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pkt", pkt_count, 0);
    check("reset_if_read", if_read, 0);
    check("read_ce", if_read_ce, 1);
    reset_n = 1'b1;
    tick();

    // 1: four-beat packet, full throughput
    acc_time.delete();
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i, (i == 3));
    start_pkt(4'd4, 1);
    exp_pkt++;
    drain("t1_drain");
    check("t1_beats", acc_time.size(), 4);
    if (acc_time.size() == 4) check("t1_consecutive", acc_time[3] - acc_time[0], 30);
    check("t1_pkt", pkt_count, exp_pkt);
    check("t1_done_cnt", done_cnt, 1);

    // 2: backpressure with tready toggling
    tog_mode = 1;
    for (int i = 0; i < 8; i++) push_word(32'hB0 + i, (i == 7));
    start_pkt(4'd8, 1);
    exp_pkt++;
    drain("t2_drain");
    tog_mode = 0;
    m_axis_tready = 1'b1;
    check("t2_pkt", pkt_count, exp_pkt);
    check("t2_done_cnt", done_cnt, 2);

    // 3: FIFO starvation after the first word
    push_word(32'hC0, 0);
    base = acc_total;
    start_pkt(4'd3, 1);
    n = 0;
    while (acc_total == base && n < 50) begin
      tick();
      n++;
    end
    check("t3_first_beat", (n < 50), 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_tvalid", m_axis_tvalid, 0);
      check("t3_stall_busy", busy, 1);
      tick();
    end
    push_word(32'hC1, 0);
    push_word(32'hC2, 1);
    exp_pkt++;
    drain("t3_drain");
    check("t3_pkt", pkt_count, exp_pkt);

    // 4: zero-length start, then start while busy
    pops_before = pop_total;
    start_pkt(4'd0, 1);
    exp_pkt++;
    tick();
    tick();
    check("t4_zero_pkt", pkt_count, exp_pkt);
    check("t4_zero_done_cnt", done_cnt, 4);
    check("t4_zero_no_pop", pop_total, pops_before);
    start_pkt(4'd3, 1);
    tick();
    check("t4_busy", busy, 1);
    start_pkt(4'd5, 0);
    push_word(32'hD0, 0);
    push_word(32'hD1, 0);
    push_word(32'hD2, 1);
    exp_pkt++;
    drain("t4_drain");
    check("t4_pkt", pkt_count, exp_pkt);
    check("t4_done_cnt", done_cnt, 5);

    // 5: reset mid-packet, then a fresh two-beat packet
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hE0 + i, (i == 5));
    base = acc_total;
    start_pkt(4'd6, 1);
    tick();
    tick();
    m_axis_tready = 1'b1;
    n = 0;
    while (acc_total < base + 2 && n < 50) begin
      tick();
      n++;
    end
    check("t5_two_beats", (n < 50), 1);
    do_reset();
    push_word(32'hF0, 0);
    push_word(32'hF1, 1);
    start_pkt(4'd2, 1);
    exp_pkt++;
    drain("t5_drain");
    check("t5_pkt", pkt_count, 1);

    // 6: pkt_count wrap with one-beat packets
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push_word(32'h600 + i, 1);
      start_pkt(4'd1, 1);
      exp_pkt++;
      drain("t6_drain");
      if (i == 14) check("t6_pkt15", pkt_count, 15);
    end
    check("t6_wrap", pkt_count, 0);
    check("t6_wrap_model", pkt_count, exp_pkt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
